clk_div_multi: RTL and testbench

- Multi-channel programmable clock divider; successor to the single-channel even-only divider in the RCC block.
- Produces NUM_CH divided clocks from REF_CLK. Supports odd and even ratios, glitch-safe run-time ratio change, per-channel graceful enable/disable, and a per-channel rising-edge tick strobe.
- Sits in the RCC between the reference clock and the peripheral clock gates; programmed by RCC registers.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_chan.sv | 103 ++++++++++
 rtl/clk_div_multi.sv | 49 ++++
 tb/tb_clk_div_multi.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: default ratio
// width, reset ratio, smallest dividing ratio and the channel state encoding.
package clk_div_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_RATIO = 2;
  // Ratios below this value put a channel into bypass (OUT_CLK = REF_CLK).
  localparam int MIN_RATIO = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // parked at cnt=0 with the output high
    ST_RUN      = 2'd1,  // dividing
    ST_STOPPING = 2'd2   // enable dropped, finishing the current period
  } ch_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow/active ratio pair and the
// IDLE -> RUN -> STOPPING -> IDLE state machine.
// Optional feature macro: CLK_DIV_PHASE_ALIGN_EN adds the sync restart input.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEFAULT_RATIO = DEF_RATIO
) (
  input  logic             REF_CLK,
  input  logic             RST,
`ifdef CLK_DIV_PHASE_ALIGN_EN
  input  logic             sync,
`endif
  input  logic             en,
  input  logic [WIDTH-1:0] ratio_in,
  input  logic             ratio_ld,
  output logic             out_clk,
  output logic             tick,
  output logic             ratio_pend,
  output logic             running
);

  ch_state_t        state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] act_reg, act_next;
  logic [WIDTH-1:0] shadow_reg, shadow_next;
  logic             div_reg, div_next;
  logic             tick_reg, tick_next;
  logic             pend_reg, pend_next;
  logic             active, at_end, wrap, apply, bypass_next;
  logic [WIDTH:0]   half_next;

  // Next-state decode: ratio hand-over, counter, FSM and the registered outputs
  always_comb begin
    active = (state_reg != ST_IDLE);
    at_end = (cnt_reg == (act_reg - WIDTH'(1)));
`ifdef CLK_DIV_PHASE_ALIGN_EN
    // A sync pulse acts as a forced wrap; coinciding with a real wrap it is one.
    wrap = active && (at_end || sync);
`else
    wrap = active && at_end;
`endif
    // Pending ratio goes live at a period boundary, or at once when not dividing.
    apply       = pend_reg && (!active || wrap);
    act_next    = apply ? shadow_reg : act_reg;
    shadow_next = ratio_ld ? ratio_in : shadow_reg;
    // A load in the apply cycle keeps the new value pending behind the old one.
    pend_next   = ratio_ld || (pend_reg && !apply);
    bypass_next = (act_next < WIDTH'(MIN_RATIO));

    state_next = state_reg;
    if (bypass_next) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:     if (en) state_next = ST_RUN;
        ST_RUN,
        ST_STOPPING: begin
          if (en)        state_next = ST_RUN;
          else if (wrap) state_next = ST_IDLE;
          else           state_next = ST_STOPPING;
        end
        default:     state_next = ST_IDLE;
      endcase
    end

    // First cycle after enable sits at cnt=0; parking also returns to 0.
    cnt_next  = (active && !wrap && (state_next != ST_IDLE)) ? cnt_reg + WIDTH'(1) : '0;
    half_next = ({1'b0, act_next} + (WIDTH + 1)'(1)) >> 1;
    div_next  = (state_next == ST_IDLE) || ({1'b0, cnt_next} < half_next);
    // Only a real period start ticks, never the enable cycle itself.
    tick_next = active && (state_next != ST_IDLE) && (cnt_next == '0);
  end

  // Channel state register with synchronous reset
  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      act_reg    <= WIDTH'(DEFAULT_RATIO);
      shadow_reg <= WIDTH'(DEFAULT_RATIO);
      div_reg    <= 1'b1;
      tick_reg   <= 1'b0;
      pend_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      act_reg    <= act_next;
      shadow_reg <= shadow_next;
      div_reg    <= div_next;
      tick_reg   <= tick_next;
      pend_reg   <= pend_next;
    end
  end

  // Ratios 0 and 1 pass the reference clock straight through.
  assign out_clk    = (act_reg < WIDTH'(MIN_RATIO)) ? REF_CLK : div_reg;
  assign tick       = tick_reg;
  assign ratio_pend = pend_reg;
  assign running    = (state_reg != ST_IDLE);

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent channels
// driven from REF_CLK, each with its own ratio slice, load strobe and enable.
// Optional feature macro: CLK_DIV_PHASE_ALIGN_EN adds the SYNC port, which
// restarts every running channel at cnt=0 on the following cycle.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEFAULT_RATIO = DEF_RATIO
) (
  input  logic                    REF_CLK,
  input  logic                    RST,
`ifdef CLK_DIV_PHASE_ALIGN_EN
  input  logic                    SYNC,
`endif
  input  logic [NUM_CH-1:0]       CH_EN,
  input  logic [NUM_CH*WIDTH-1:0] RATIO_IN,
  input  logic [NUM_CH-1:0]       RATIO_LD,
  output logic [NUM_CH-1:0]       OUT_CLK,
  output logic [NUM_CH-1:0]       TICK,
  output logic [NUM_CH-1:0]       RATIO_PEND,
  output logic [NUM_CH-1:0]       RUNNING
);

  // One channel per bit, each taking its own slice of the flat ratio bus
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      clk_div_chan #(
        .WIDTH         (WIDTH),
        .DEFAULT_RATIO (DEFAULT_RATIO)
      ) u_chan (
        .REF_CLK    (REF_CLK),
        .RST        (RST),
`ifdef CLK_DIV_PHASE_ALIGN_EN
        .sync       (SYNC),
`endif
        .en         (CH_EN[gi]),
        .ratio_in   (RATIO_IN[gi*WIDTH +: WIDTH]),
        .ratio_ld   (RATIO_LD[gi]),
        .out_clk    (OUT_CLK[gi]),
        .tick       (TICK[gi]),
        .ratio_pend (RATIO_PEND[gi]),
        .running    (RUNNING[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a per-cycle vector table for the basic
// ratio-2 / ratio-5 / reload behaviour plus hand sequences for bypass,
// graceful disable, re-enable, reset mid-period and (optionally) SYNC.
module tb_clk_div_multi;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;

  logic                    REF_CLK = 1'b0;
  logic                    RST;
  logic [NUM_CH-1:0]       CH_EN;
  logic [NUM_CH*WIDTH-1:0] RATIO_IN;
  logic [NUM_CH-1:0]       RATIO_LD;
  logic [NUM_CH-1:0]       OUT_CLK;
  logic [NUM_CH-1:0]       TICK;
  logic [NUM_CH-1:0]       RATIO_PEND;
  logic [NUM_CH-1:0]       RUNNING;
`ifdef CLK_DIV_PHASE_ALIGN_EN
  logic                    SYNC;
`endif

  int checks = 0;
  int errors = 0;

  always #5 REF_CLK = ~REF_CLK;

  clk_div_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEFAULT_RATIO(2)) dut (
    .REF_CLK    (REF_CLK),
    .RST        (RST),
`ifdef CLK_DIV_PHASE_ALIGN_EN
    .SYNC       (SYNC),
`endif
    .CH_EN      (CH_EN),
    .RATIO_IN   (RATIO_IN),
    .RATIO_LD   (RATIO_LD),
    .OUT_CLK    (OUT_CLK),
    .TICK       (TICK),
    .RATIO_PEND (RATIO_PEND),
    .RUNNING    (RUNNING)
  );

  typedef struct {
    logic       rst;
    logic [3:0] en;
    logic [3:0] ld;
    logic [7:0] ratio;
    logic [3:0] out;
    logic [3:0] tick;
    logic [3:0] pend;
    logic [3:0] run;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic r, input logic [3:0] e, input logic [3:0] l,
                              input logic [7:0] ra, input logic [3:0] o, input logic [3:0] t,
                              input logic [3:0] p, input logic [3:0] rn);
    vec_t v;
    v.rst = r; v.en = e; v.ld = l; v.ratio = ra;
    v.out = o; v.tick = t; v.pend = p; v.run = rn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic cycle();
    @(posedge REF_CLK);
    @(negedge REF_CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; CH_EN = '0; RATIO_LD = '0;
    cycle();
    RST = 1'b0;
  endtask

  task automatic load(input logic [3:0] mask, input logic [7:0] r);
    RATIO_IN = {4{r}};
    RATIO_LD = mask;
    cycle();
    RATIO_LD = '0;
  endtask

  initial begin
    RST = 1'b1; CH_EN = '0; RATIO_IN = '0; RATIO_LD = '0;
`ifdef CLK_DIV_PHASE_ALIGN_EN
    SYNC = 1'b0;
`endif

    //              rst en   ld   ratio out   tick  pend  run
    tbl[0]  = mk(1'b1, 4'h0, 4'h0, 8'd0, 4'hF, 4'h0, 4'h0, 4'h0);
    tbl[1]  = mk(1'b0, 4'h1, 4'h0, 8'd0, 4'hF, 4'h0, 4'h0, 4'h1);
    tbl[2]  = mk(1'b0, 4'h1, 4'h0, 8'd0, 4'hE, 4'h0, 4'h0, 4'h1);
    tbl[3]  = mk(1'b0, 4'h1, 4'h2, 8'd5, 4'hF, 4'h1, 4'h2, 4'h1);
    tbl[4]  = mk(1'b0, 4'h1, 4'h0, 8'd0, 4'hE, 4'h0, 4'h0, 4'h1);
    tbl[5]  = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hF, 4'h1, 4'h0, 4'h3);
    tbl[6]  = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hE, 4'h0, 4'h0, 4'h3);
    tbl[7]  = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hF, 4'h1, 4'h0, 4'h3);
    tbl[8]  = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hC, 4'h0, 4'h0, 4'h3);
    tbl[9]  = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hD, 4'h1, 4'h0, 4'h3);
    tbl[10] = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hE, 4'h2, 4'h0, 4'h3);
    tbl[11] = mk(1'b0, 4'h3, 4'h2, 8'd4, 4'hF, 4'h1, 4'h2, 4'h3);
    tbl[12] = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hE, 4'h0, 4'h2, 4'h3);
    tbl[13] = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hD, 4'h1, 4'h2, 4'h3);
    tbl[14] = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hC, 4'h0, 4'h2, 4'h3);
    tbl[15] = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hF, 4'h3, 4'h0, 4'h3);
    tbl[16] = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hE, 4'h0, 4'h0, 4'h3);
    tbl[17] = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hD, 4'h1, 4'h0, 4'h3);
    tbl[18] = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hC, 4'h0, 4'h0, 4'h3);
    tbl[19] = mk(1'b0, 4'h3, 4'h0, 8'd0, 4'hF, 4'h3, 4'h0, 4'h3);

    // Table: ch0 ratio 2, ch1 loaded to 5, then reloaded to 4 mid-period
    for (int i = 0; i < 20; i++) begin
      RST      = tbl[i].rst;
      CH_EN    = tbl[i].en;
      RATIO_LD = tbl[i].ld;
      RATIO_IN = {4{tbl[i].ratio}};
      cycle();
      $display("vec %0d: out=%b tick=%b pend=%b run=%b", i, OUT_CLK, TICK, RATIO_PEND, RUNNING);
      check($sformatf("vec%0d_out", i),  32'(OUT_CLK),    32'(tbl[i].out));
      check($sformatf("vec%0d_tick", i), 32'(TICK),       32'(tbl[i].tick));
      check($sformatf("vec%0d_pend", i), 32'(RATIO_PEND), 32'(tbl[i].pend));
      check($sformatf("vec%0d_run", i),  32'(RUNNING),    32'(tbl[i].run));
    end
    RATIO_LD = '0;

    // Bypass on ch2: ratio 1, then 0, then 6 resumes dividing from cnt=0
    do_reset();
    for (int r = 1; r >= 0; r--) begin
      load(4'h4, 8'(r));
      check("byp_pend_set", 32'(RATIO_PEND[2]), 32'(1));
      cycle();
      check("byp_pend_clr", 32'(RATIO_PEND[2]), 32'(0));
      CH_EN[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(posedge REF_CLK);
        #1;
        check("byp_out_hi", 32'(OUT_CLK[2]), 32'(1));
        @(negedge REF_CLK);
        $display("bypass ratio %0d cycle %0d: out=%b tick=%b run=%b", r, k, OUT_CLK[2], TICK[2], RUNNING[2]);
        check("byp_out_lo", 32'(OUT_CLK[2]), 32'(0));
        check("byp_tick",   32'(TICK[2]),    32'(0));
        check("byp_run",    32'(RUNNING[2]), 32'(0));
      end
    end
    load(4'h4, 8'd6);
    check("r6_still_byp", 32'(OUT_CLK[2]), 32'(0));
    cycle();
    check("r6_start_out",  32'(OUT_CLK[2]),    32'(1));
    check("r6_start_run",  32'(RUNNING[2]),    32'(1));
    check("r6_start_tick", 32'(TICK[2]),       32'(0));
    check("r6_start_pend", 32'(RATIO_PEND[2]), 32'(0));
    for (int k = 1; k <= 12; k++) begin
      cycle();
      $display("ratio6 k=%0d: out=%b tick=%b", k, OUT_CLK[2], TICK[2]);
      check("r6_out",  32'(OUT_CLK[2]), 32'((k % 6) < 3));
      check("r6_tick", 32'(TICK[2]),    32'((k % 6) == 0));
    end

    // Graceful disable on ch3 at ratio 8: drop enable at cnt=1
    do_reset();
    load(4'h8, 8'd8);
    cycle();
    CH_EN[3] = 1'b1;
    cycle();
    check("dis_en_run", 32'(RUNNING[3]), 32'(1));
    check("dis_en_out", 32'(OUT_CLK[3]), 32'(1));
    for (int k = 1; k <= 10; k++) begin
      CH_EN[3] = (k < 2);
      cycle();
      $display("disable k=%0d: out=%b tick=%b run=%b", k, OUT_CLK[3], TICK[3], RUNNING[3]);
      check("dis_out",  32'(OUT_CLK[3]), 32'((k >= 8) || (k < 4)));
      check("dis_run",  32'(RUNNING[3]), 32'(k < 8));
      check("dis_tick", 32'(TICK[3]),    32'(0));
    end

    // Re-enable while stopping: counting continues uninterrupted
    CH_EN[3] = 1'b1;
    cycle();
    check("reen_run0", 32'(RUNNING[3]), 32'(1));
    for (int k = 1; k <= 16; k++) begin
      CH_EN[3] = !((k == 2) || (k == 3));
      cycle();
      $display("reenable k=%0d: out=%b tick=%b run=%b", k, OUT_CLK[3], TICK[3], RUNNING[3]);
      check("reen_out",  32'(OUT_CLK[3]), 32'((k % 8) < 4));
      check("reen_tick", 32'(TICK[3]),    32'((k % 8) == 0));
      check("reen_run",  32'(RUNNING[3]), 32'(1));
    end

    // Reset in the low phase of ratio 7 on ch0, with a load strobe alongside
    do_reset();
    load(4'h1, 8'd7);
    cycle();
    CH_EN[0] = 1'b1;
    cycle();
    for (int k = 1; k <= 5; k++) cycle();
    check("r7_low", 32'(OUT_CLK[0]), 32'(0));
    RST = 1'b1;
    RATIO_IN = {4{8'd9}};
    RATIO_LD = 4'h2;
    cycle();
    RST = 1'b0;
    RATIO_LD = '0;
    $display("reset mid-period: out=%b tick=%b pend=%b run=%b", OUT_CLK, TICK, RATIO_PEND, RUNNING);
    check("rst_out",  32'(OUT_CLK),    32'(4'hF));
    check("rst_tick", 32'(TICK),       32'(0));
    check("rst_pend", 32'(RATIO_PEND), 32'(0));
    check("rst_run",  32'(RUNNING),    32'(0));
    cycle();
    check("rst_def_run", 32'(RUNNING[0]), 32'(1));
    check("rst_def_o0",  32'(OUT_CLK[0]), 32'(1));
    cycle();
    check("rst_def_o1",  32'(OUT_CLK[0]), 32'(0));
    cycle();
    check("rst_def_o2",  32'(OUT_CLK[0]), 32'(1));
    check("rst_def_t2",  32'(TICK[0]),    32'(1));

`ifdef CLK_DIV_PHASE_ALIGN_EN
    // SYNC aligns ch0 (ratio 3) and ch1 (ratio 6) that started out of phase
    do_reset();
    RATIO_IN = {8'd0, 8'd0, 8'd6, 8'd3};
    RATIO_LD = 4'h3;
    cycle();
    RATIO_LD = '0;
    cycle();
    CH_EN = 4'h1;
    cycle();
    cycle();
    CH_EN = 4'h3;
    cycle();
    cycle();
    SYNC = 1'b1;
    cycle();
    SYNC = 1'b0;
    check("sync_tick", 32'(TICK[1:0]),    32'(2'b11));
    check("sync_out",  32'(OUT_CLK[1:0]), 32'(2'b11));
    for (int k = 1; k <= 12; k++) begin
      cycle();
      $display("sync k=%0d: out=%b tick=%b", k, OUT_CLK[1:0], TICK[1:0]);
      check("sync_o0", 32'(OUT_CLK[0]), 32'((k % 3) < 2));
      check("sync_t0", 32'(TICK[0]),    32'((k % 3) == 0));
      check("sync_o1", 32'(OUT_CLK[1]), 32'((k % 6) < 3));
      check("sync_t1", 32'(TICK[1]),    32'((k % 6) == 0));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
